sram_avalon_ctrl: RTL and testbench
===================================

SRAM_AVALON_CTRL -- requirements
Module: sram_avalon_ctrl

Interface
REQ-001 The block SHALL have parameter READ_CYCLES, default 2, giving the number of clocks the SRAM is held in read access (range 1..15).
REQ-002 The block SHALL have parameter WRITE_CYCLES, default 2, giving the number of clocks SRAM_WE_N is held low (range 1..15).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Ports SHALL be:
 clk_clk  in  1  system clock, 50 MHz
 reset_reset  in  1  synchronous active-high reset
 avs_address  in  19  16-bit word address
 avs_read  in  1  read request
 avs_write  in  1  write request
 avs_byteenable  in  2  byte lanes; bit1=D[15:8], bit0=D[7:0]
 avs_writedata  in  16  write data
 avs_readdata  out  16  read data, valid with avs_readdatavalid
 avs_readdatavalid  out  1  one-cycle read-return strobe
 avs_waitrequest  out  1  high = request not accepted
 SRAM_A  out  19  SRAM address
 SRAM_D  inout  16  SRAM data bus
 SRAM_CE_N, SRAM_OE_N, SRAM_WE_N  out  1  active-low strobes
 SRAM_BE_N  out  2  active-low byte enables

Function
REQ-005 avs_waitrequest SHALL be 0 only in state IDLE; a request is accepted on a rising edge where state is IDLE and avs_read or avs_write is 1.
REQ-006 At acceptance the block SHALL register address, writedata and byteenable; later input changes SHALL not affect the transaction.
REQ-007 If avs_read and avs_write are both 1 at acceptance, the block SHALL perform the write only, with no readdatavalid.
REQ-008 FSM states SHALL be IDLE, RD_ACCESS, WR_SETUP, WR_PULSE, WR_HOLD.
REQ-009 Read: IDLE -> RD_ACCESS for READ_CYCLES clocks with SRAM_CE_N=0, SRAM_OE_N=0, SRAM_BE_N=00, SRAM_A=latched address, SRAM_D released.
REQ-010 SRAM_D SHALL be sampled into avs_readdata at the edge that ends the last RD_ACCESS clock; avs_readdatavalid SHALL be 1 for exactly the following clock, with the FSM back in IDLE.
REQ-011 Read latency SHALL be READ_CYCLES+1 clocks from the acceptance edge to avs_readdatavalid high; a new request SHALL be acceptable in the same clock as that strobe.
REQ-012 Write: WR_SETUP (1 clock, CE_N=0, WE_N=1, data driven) -> WR_PULSE (WRITE_CYCLES clocks, WE_N=0) -> WR_HOLD (1 clock, WE_N=1, CE_N=0, data still driven) -> IDLE; total WRITE_CYCLES+2 busy clocks.
REQ-013 During writes SRAM_BE_N SHALL equal ~latched byteenable; byteenable=00 SHALL run the full sequence with SRAM_WE_N held 1.
REQ-014 SRAM_D SHALL be driven only in WR_SETUP, WR_PULSE and WR_HOLD, and SHALL be high-impedance otherwise; SRAM_OE_N SHALL be 1 whenever SRAM_D is driven.
REQ-015 The wait counter SHALL be 4 bits, load at state entry, and never wrap; a counter value of 0 ends the state.
REQ-016 All SRAM outputs SHALL be registered; no combinational path SHALL run from Avalon inputs to SRAM pins.

Reset
REQ-017 While reset_reset=1: state=IDLE, SRAM_CE_N=SRAM_OE_N=SRAM_WE_N=1, SRAM_BE_N=11, SRAM_A=0, SRAM_D released, avs_readdata=0, avs_readdatavalid=0, avs_waitrequest=1.
REQ-018 Reset asserted mid-transaction SHALL abort it on the next edge with no readdatavalid emitted; WE_N SHALL go to 1 on that edge.
REQ-019 The first request SHALL be accepted no earlier than the first clock after reset_reset deasserts.

Structure
REQ-020 Package sram_ctrl_pkg SHALL hold the state enumeration, SRAM_ADDR_W=19, SRAM_DATA_W=16 and SRAM_BE_W=2.
REQ-021 The tri-state data buffer SHALL be one sub-module, sram_io_buf (oe, dout, din, pad).

Verification
REQ-022 Write 0xA5C3 to 0x7FFFF with be=11 -> WE_N low for exactly 2 clocks, BE_N=00, A=0x7FFFF, waitrequest high for 4 clocks.
REQ-023 Read 0x7FFFF with the SRAM model returning 0xA5C3 -> readdatavalid one clock, 3 clocks after acceptance, readdata=0xA5C3.
REQ-024 Write be=01 of 0x1234 over 0xFFFF -> BE_N=10, and a subsequent read returns 0xFF34.
REQ-025 read=write=1 at 0x00010 -> write occurs, no readdatavalid strobe within 10 clocks.
REQ-026 reset_reset pulsed during WR_PULSE -> WE_N=1, D released and waitrequest=1 on the next edge; no strobe follows.
REQ-027 Back-to-back reads at 0x00000 and 0x00001 -> the second is accepted in the clock of the first readdatavalid, and strobes are 3 clocks apart.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared widths and FSM states for the Avalon-MM SRAM controller
package sram_ctrl_pkg;
  localparam int SRAM_ADDR_W = 19;
  localparam int SRAM_DATA_W = 16;
  localparam int SRAM_BE_W = 2;
  typedef enum logic [2:0] {IDLE, RD_ACCESS, WR_SETUP, WR_PULSE, WR_HOLD} state_t;
endpackage

// File: rtl/sram_io_buf.sv
// sram_io_buf: tri-state buffer for the bidirectional SRAM data bus
module sram_io_buf
  import sram_ctrl_pkg::*;
(
  input  logic                   oe,
  input  logic [SRAM_DATA_W-1:0] dout,
  output logic [SRAM_DATA_W-1:0] din,
  inout  wire  [SRAM_DATA_W-1:0] pad
);
  assign pad = oe ? dout : 'z;
  assign din = pad;
endmodule

// File: rtl/sram_avalon_ctrl.sv
// sram_avalon_ctrl: Avalon-MM slave driving an asynchronous 16-bit SRAM with fully registered pins
module sram_avalon_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int READ_CYCLES = 2,
  parameter int WRITE_CYCLES = 2
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset,
  input  logic [SRAM_ADDR_W-1:0] avs_address,
  input  logic                   avs_read,
  input  logic                   avs_write,
  input  logic [SRAM_BE_W-1:0]   avs_byteenable,
  input  logic [SRAM_DATA_W-1:0] avs_writedata,
  output logic [SRAM_DATA_W-1:0] avs_readdata,
  output logic                   avs_readdatavalid,
  output logic                   avs_waitrequest,
  output logic [SRAM_ADDR_W-1:0] SRAM_A,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_D,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_WE_N,
  output logic [SRAM_BE_W-1:0]   SRAM_BE_N
);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [SRAM_DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d, din;
  logic [SRAM_BE_W-1:0] be_q, be_d, be_n_q, be_n_d;
  logic ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d, doe_q, doe_d, rvalid_q, rvalid_d;
  logic accept, rd, wr;
  // Pin values are computed from the next state so every SRAM output comes straight from a flop
  always_comb begin
    accept = state_q == IDLE && (avs_read || avs_write);
    state_d = state_q;
    cnt_d = cnt_q != 4'd0 ? cnt_q - 4'd1 : cnt_q;
    addr_d = accept ? avs_address : addr_q;
    wdata_d = accept ? avs_writedata : wdata_q;
    be_d = accept ? avs_byteenable : be_q;
    rdata_d = rdata_q;
    rvalid_d = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        state_d = avs_write ? WR_SETUP : RD_ACCESS;
        cnt_d = 4'(READ_CYCLES - 1);
      end
      RD_ACCESS: if (cnt_q == 4'd0) begin
        state_d = IDLE;
        rdata_d = din;
        rvalid_d = 1'b1;
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d = 4'(WRITE_CYCLES - 1);
      end
      WR_PULSE: state_d = cnt_q == 4'd0 ? WR_HOLD : WR_PULSE;
      default: state_d = IDLE;
    endcase
    rd = state_d == RD_ACCESS;
    wr = state_d inside {WR_SETUP, WR_PULSE, WR_HOLD};
    ce_n_d = !(rd || wr);
    oe_n_d = !rd;
    we_n_d = !(state_d == WR_PULSE && |be_d);
    doe_d = wr;
    be_n_d = rd ? '0 : wr ? ~be_d : '1;
  end
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      rdata_q <= '0;
      rvalid_q <= 1'b0;
      ce_n_q <= 1'b1;
      oe_n_q <= 1'b1;
      we_n_q <= 1'b1;
      doe_q <= 1'b0;
      be_n_q <= '1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      be_q <= be_d;
      rdata_q <= rdata_d;
      rvalid_q <= rvalid_d;
      ce_n_q <= ce_n_d;
      oe_n_q <= oe_n_d;
      we_n_q <= we_n_d;
      doe_q <= doe_d;
      be_n_q <= be_n_d;
    end
  end
  sram_io_buf u_io (.oe(doe_q), .dout(wdata_q), .din(din), .pad(SRAM_D));
  assign avs_waitrequest = reset_reset || state_q != IDLE;
  assign avs_readdata = rdata_q;
  assign avs_readdatavalid = rvalid_q;
  assign SRAM_A = addr_q;
  assign SRAM_CE_N = ce_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_BE_N = be_n_q;
endmodule

// File: tb/tb_sram_avalon_ctrl.sv
// tb_sram_avalon_ctrl: random and directed Avalon traffic against an SRAM model, checked by read/write scoreboards
module tb_sram_avalon_ctrl;
  localparam int READ_CYCLES = 2;
  localparam int WRITE_CYCLES = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic [18:0] avs_address;
  logic avs_read, avs_write;
  logic [1:0] avs_byteenable;
  logic [15:0] avs_writedata, avs_readdata;
  logic avs_readdatavalid, avs_waitrequest;
  logic [18:0] sram_a;
  wire [15:0] sram_d;
  logic sram_ce_n, sram_oe_n, sram_we_n;
  logic [1:0] sram_be_n;
  always #10 clk = ~clk;
  sram_avalon_ctrl #(.READ_CYCLES(READ_CYCLES), .WRITE_CYCLES(WRITE_CYCLES)) u_dut (
    .clk_clk(clk), .reset_reset(rst), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_byteenable(avs_byteenable), .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
    .avs_waitrequest(avs_waitrequest), .SRAM_A(sram_a), .SRAM_D(sram_d),
    .SRAM_CE_N(sram_ce_n), .SRAM_OE_N(sram_oe_n), .SRAM_WE_N(sram_we_n), .SRAM_BE_N(sram_be_n)
  );
  // Asynchronous SRAM model: drives the bus on read, captures enabled byte lanes while WE_N is low
  logic [15:0] mem [0:(1<<19)-1];
  logic mdrv;
  assign mdrv = !sram_ce_n && !sram_oe_n && sram_we_n;
  assign sram_d = mdrv ? mem[sram_a] : 'z;
  always @(posedge clk)
    if (!sram_ce_n && !sram_we_n) begin
      if (!sram_be_n[1]) mem[sram_a][15:8] <= sram_d[15:8];
      if (!sram_be_n[0]) mem[sram_a][7:0] <= sram_d[7:0];
    end
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  typedef struct {logic [15:0] data; int due;} rexp_t;
  typedef struct {logic [18:0] a; logic [1:0] be_n; logic [15:0] d;} wexp_t;
  rexp_t rq[$];
  wexp_t wq[$];
  logic [15:0] ref_mem [int];
  function automatic logic [15:0] ref_rd(input logic [18:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0;
  endfunction
  // Issue one Avalon request at a negedge; expectations are recorded when waitrequest lets it in
  task automatic req(input logic rd, input logic wr, input logic [18:0] a, input logic [1:0] be, input logic [15:0] d);
    int t = 0;
    logic [15:0] old;
    avs_read = rd; avs_write = wr; avs_address = a; avs_byteenable = be; avs_writedata = d;
    while (avs_waitrequest && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("accept_timeout", 32'(t < 50), 1);
    if (wr) begin
      old = ref_rd(a);
      ref_mem[int'(a)] = {be[1] ? d[15:8] : old[15:8], be[0] ? d[7:0] : old[7:0]};
      if (|be) wq.push_back('{a, ~be, d});
    end else rq.push_back('{ref_rd(a), cyc + READ_CYCLES + 1});
    @(negedge clk);
    avs_read = 0; avs_write = 0;
    avs_address = 19'($urandom); avs_byteenable = 2'($urandom); avs_writedata = 16'($urandom);
  endtask
  rexp_t re;
  wexp_t we;
  logic prev_we = 1'b1, aborted = 1'b0;
  int run = 0;
  always @(negedge clk) begin
    if (rq.size() == 0) chk("stray_rvalid", 32'(avs_readdatavalid), 0);
    else if (avs_readdatavalid || cyc >= rq[0].due) begin
      re = rq.pop_front();
      chk("rvalid_cycle", avs_readdatavalid ? cyc : -1, re.due);
      if (avs_readdatavalid) chk("rdata", 32'(avs_readdata), 32'(re.data));
    end
    if (!sram_we_n && prev_we) begin
      if (wq.size() == 0) chk("stray_we", 32'(sram_we_n), 1);
      else begin
        we = wq.pop_front();
        chk("wr_addr", 32'(sram_a), 32'(we.a));
        chk("wr_be_n", 32'(sram_be_n), 32'(we.be_n));
        chk("wr_data", 32'(sram_d), 32'(we.d));
        chk("wr_ce_n", 32'(sram_ce_n), 0);
      end
      run = 0;
      aborted = 1'b0;
    end
    if (!sram_we_n) run++;
    if (rst) aborted = 1'b1;
    if (sram_we_n && !prev_we && !aborted) chk("we_pulse_len", run, WRITE_CYCLES);
    if (u_dut.u_io.oe) chk("oe_n_while_driving", 32'(sram_oe_n), 1);
    prev_we = sram_we_n;
  end
  initial begin
    int t;
    for (int i = 0; i < (1 << 19); i++) mem[i] = 16'h0;
    avs_read = 0; avs_write = 0; avs_address = '0; avs_byteenable = '0; avs_writedata = '0;
    repeat (3) @(negedge clk);
    avs_read = 1;
    avs_address = 19'h155;
    @(negedge clk);
    chk("rst_waitrequest", 32'(avs_waitrequest), 1);
    chk("rst_strobes", {29'b0, sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
    chk("rst_be_n", 32'(sram_be_n), 2'b11);
    chk("rst_addr", 32'(sram_a), 0);
    chk("rst_readdata", 32'(avs_readdata), 0);
    chk("rst_rvalid", 32'(avs_readdatavalid), 0);
    chk("rst_d_released", 32'(u_dut.u_io.oe), 0);
    avs_read = 0;
    rst = 0;
    @(negedge clk);
    chk("idle_waitrequest", 32'(avs_waitrequest), 0);
    req(0, 1, 19'h7FFFF, 2'b11, 16'hA5C3);
    for (int i = 0; i < 4; i++) begin
      chk("write_busy", 32'(avs_waitrequest), 1);
      @(negedge clk);
    end
    chk("write_done", 32'(avs_waitrequest), 0);
    req(1, 0, 19'h7FFFF, 2'b11, 16'h0);
    repeat (3) @(negedge clk);
    req(0, 1, 19'h00100, 2'b11, 16'hFFFF);
    req(0, 1, 19'h00100, 2'b01, 16'h1234);
    req(1, 0, 19'h00100, 2'b00, 16'h0);
    req(1, 1, 19'h00010, 2'b11, 16'hBEEF);
    repeat (10) @(negedge clk);
    req(1, 0, 19'h00010, 2'b11, 16'h0);
    repeat (3) @(negedge clk);
    req(0, 1, 19'h00020, 2'b11, 16'h5555);
    t = 0;
    while (sram_we_n && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("we_seen", 32'(sram_we_n), 0);
    rst = 1;
    @(negedge clk);
    chk("abort_we_n", 32'(sram_we_n), 1);
    chk("abort_d_released", 32'(u_dut.u_io.oe), 0);
    chk("abort_waitrequest", 32'(avs_waitrequest), 1);
    @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    req(1, 0, 19'h00000, 2'b11, 16'h0);
    req(1, 0, 19'h00001, 2'b11, 16'h0);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 60; i++) begin
      int op;
      op = $urandom_range(0, 3);
      req(op == 0 || op == 3, op != 0, 19'($urandom_range(0, 15)), 2'($urandom), 16'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    for (int i = 0; i < 16; i++) req(1, 0, 19'(i), 2'b11, 16'h0);
    t = 0;
    while ((rq.size() != 0 || wq.size() != 0) && t < 30) begin
      @(negedge clk);
      t++;
    end
    chk("rq_drained", rq.size(), 0);
    chk("wq_drained", wq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
